serial_chunk_adder: RTL and testbench

//   Multi-cycle add/subtract unit. Adds two WIDTH-bit operands CHUNK bits per clock

---
 rtl/serial_chunk_adder_if.sv | 35 +++
 rtl/serial_chunk_adder.sv | 160 ++++++++++++++++
 tb/tb_serial_chunk_adder.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_chunk_adder_if.sv
// serial_chunk_adder_if: operand and result channels of the chunked add/subtract unit.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are both
// high. A producer holds valid and its payload stable until that edge. A consumer may
// raise ready before, after or together with valid. The operand channel (in_*) flows
// master -> slave and the result channel (out_*, sum, cout, ovf) flows slave -> master.
interface serial_chunk_adder_if #(
   parameter int WIDTH = 32
);
   // operand channel
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   // result channel
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   // operand producer / result consumer side
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   // the adder itself
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: WIDTH-bit add/subtract that walks the operands CHUNK bits per
// clock, LSB chunk first, through a registered carry. One operation is in flight at a
// time: IDLE (accept operands) -> RUN (N chunk cycles) -> DONE (hold result) -> IDLE.
// Subtraction is a + ~b + ~cin, so cout=1 means "no borrow".
module serial_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_chunk_adder_if.slave bus,
   output logic [1:0]          state_dbg   // 0 IDLE, 1 RUN, 2 DONE
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] K_LAST = CW'(N - 1);

   // A partial final chunk would silently drop operand bits, so refuse to build.
   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("serial_chunk_adder: WIDTH %0d is not a multiple of CHUNK %0d", WIDTH, CHUNK);
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;

   // operands as latched at acceptance; b_q already holds ~b for subtraction
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] part_q;     // chunks of the result produced so far
   logic             carry_q;    // carry into the chunk being processed
   logic [CW-1:0]    k_q;        // index of the chunk being processed

   // published result, changes only on entry to DONE
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic             in_ready_c;
   logic             out_valid_c;
   logic             accept;
   logic             last;

   logic [CHUNK-1:0] a_chunk;
   logic [CHUNK-1:0] b_chunk;
   logic [CHUNK:0]   slice;
   logic [CHUNK-1:0] s_chunk;
   logic             c_top;      // carry out of the current chunk
   logic             c_msb;      // carry into the top bit of the current chunk
   logic [WIDTH-1:0] full_sum;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; ready/valid are pure functions of the state.
   always_comb begin
      state_d     = state_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign accept = bus.in_valid && in_ready_c;
   assign last   = (k_q == K_LAST);

   // One CHUNK-bit slice adder; the carry into its top bit gives signed overflow on the
   // final chunk without a second adder.
   always_comb begin
      a_chunk  = a_q[int'(k_q) * CHUNK +: CHUNK];
      b_chunk  = b_q[int'(k_q) * CHUNK +: CHUNK];
      slice    = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
      s_chunk  = slice[CHUNK-1:0];
      c_top    = slice[CHUNK];
      c_msb    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ s_chunk[CHUNK-1];
      full_sum = part_q;
      full_sum[(N-1) * CHUNK +: CHUNK] = s_chunk;
   end

   // Operand capture at acceptance, chunk-by-chunk accumulation in RUN, result publish
   // on the last chunk. The published result is untouched in IDLE and RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  a_q     <= bus.a;
                  b_q     <= bus.sub ? ~bus.b : bus.b;
                  carry_q <= bus.sub ? ~bus.cin : bus.cin;
                  k_q     <= '0;
               end
            end
            S_RUN: begin
               part_q[int'(k_q) * CHUNK +: CHUNK] <= s_chunk;
               carry_q <= c_top;
               if (last) begin
                  k_q    <= '0;
                  sum_q  <= full_sum;
                  cout_q <= c_top;
                  ovf_q  <= c_msb ^ c_top;
               end else begin
                  k_q <= k_q + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: three adder configurations on one clock.
//   unit 0: WIDTH 32 / CHUNK 4 (directed vectors and corner sequences)
//   unit 1: WIDTH  8 / CHUNK 8 (single-cycle RUN, random traffic)
//   unit 2: WIDTH 16 / CHUNK 2 (random traffic)
`timescale 1ns/1ps
module tb_serial_chunk_adder;

   localparam int NU = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUTs ----------------
   serial_chunk_adder_if #(.WIDTH(32)) bus32 ();
   serial_chunk_adder_if #(.WIDTH(8))  bus8  ();
   serial_chunk_adder_if #(.WIDTH(16)) bus16 ();

   logic [1:0] dbg32, dbg8, dbg16;

   serial_chunk_adder #(.WIDTH(32), .CHUNK(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32), .state_dbg(dbg32));
   serial_chunk_adder #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8),  .state_dbg(dbg8));
   serial_chunk_adder #(.WIDTH(16), .CHUNK(2)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16), .state_dbg(dbg16));

   // per-unit drive registers
   logic        d_valid [NU];
   logic        d_oready[NU];
   logic        d_cin   [NU];
   logic        d_sub   [NU];
   logic [31:0] d_a     [NU];
   logic [31:0] d_b     [NU];

   assign bus32.in_valid  = d_valid[0];
   assign bus32.out_ready = d_oready[0];
   assign bus32.cin       = d_cin[0];
   assign bus32.sub       = d_sub[0];
   assign bus32.a         = d_a[0];
   assign bus32.b         = d_b[0];

   assign bus8.in_valid   = d_valid[1];
   assign bus8.out_ready  = d_oready[1];
   assign bus8.cin        = d_cin[1];
   assign bus8.sub        = d_sub[1];
   assign bus8.a          = d_a[1][7:0];
   assign bus8.b          = d_b[1][7:0];

   assign bus16.in_valid  = d_valid[2];
   assign bus16.out_ready = d_oready[2];
   assign bus16.cin       = d_cin[2];
   assign bus16.sub       = d_sub[2];
   assign bus16.a         = d_a[2][15:0];
   assign bus16.b         = d_b[2][15:0];

   function automatic int w_of(input int u);
      case (u)
         0:       return 32;
         1:       return 8;
         default: return 16;
      endcase
   endfunction

   function automatic int n_of(input int u);
      case (u)
         0:       return 8;
         1:       return 1;
         default: return 8;
      endcase
   endfunction

   function automatic logic get_iready(input int u);
      case (u)
         0:       return bus32.in_ready;
         1:       return bus8.in_ready;
         default: return bus16.in_ready;
      endcase
   endfunction

   function automatic logic get_ovalid(input int u);
      case (u)
         0:       return bus32.out_valid;
         1:       return bus8.out_valid;
         default: return bus16.out_valid;
      endcase
   endfunction

   function automatic logic [1:0] get_dbg(input int u);
      case (u)
         0:       return dbg32;
         1:       return dbg8;
         default: return dbg16;
      endcase
   endfunction

   // {ovf, cout, sum zero-extended to 32}
   function automatic logic [33:0] get_res(input int u);
      case (u)
         0:       return {bus32.ovf, bus32.cout, bus32.sum};
         1:       return {bus8.ovf,  bus8.cout,  24'd0, bus8.sum};
         default: return {bus16.ovf, bus16.cout, 16'd0, bus16.sum};
      endcase
   endfunction

   // ---------------- reference model ----------------
   // Plain integer arithmetic: unsigned result for sum/cout, signed result for ovf.
   function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub);
      longint lim, half, ua, ub, sa, sb, c, ur, sr;
      logic [31:0] s;
      logic co, ov;
      lim  = longint'(1) << w;
      half = lim / 2;
      ua   = longint'(a) & (lim - 1);
      ub   = longint'(b) & (lim - 1);
      c    = cin ? 1 : 0;
      sa   = (ua >= half) ? ua - lim : ua;
      sb   = (ub >= half) ? ub - lim : ub;
      ur   = sub ? ua - ub - c : ua + ub + c;
      sr   = sub ? sa - sb - c : sa + sb + c;
      s    = 32'((ur % lim + lim) % lim);
      co   = sub ? (ur >= 0) : (ur >= lim);
      ov   = (sr >= half) || (sr < -half);
      return {ov, co, s};
   endfunction

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
   task automatic send(input int u, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic sub);
      int n;
      n = 0;
      d_a[u]     = a;
      d_b[u]     = b;
      d_cin[u]   = cin;
      d_sub[u]   = sub;
      d_valid[u] = 1'b1;
      while (!get_iready(u) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL u%0d_send_timeout: in_ready low for %0d cycles, required high", u, n);
      end
      @(posedge clk);
      @(negedge clk);
      d_valid[u] = 1'b0;
   endtask

   task automatic wait_ovalid(input int u, output int lat);
      lat = 0;
      while (!get_ovalid(u) && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 100) begin
         checks++;
         errors++;
         $display("FAIL u%0d_result_timeout: out_valid low for %0d cycles, required high", u, lat);
      end
   endtask

   task automatic recv(input int u, input int stall, input logic early,
                       output logic [33:0] res, output int lat);
      d_oready[u] = early;
      wait_ovalid(u, lat);
      res = get_res(u);
      if (!early) begin
         repeat (stall) @(negedge clk);
         d_oready[u] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      d_oready[u] = 1'b0;
      check($sformatf("u%0d_valid_after_consume", u), 64'(get_ovalid(u)), 64'd0);
   endtask

   function automatic logic [31:0] pick(input int w);
      logic [31:0] mask, msb;
      mask = 32'((longint'(1) << w) - 1);
      msb  = 32'(1) << (w - 1);
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return mask;
         2:       return msb;
         3:       return msb - 32'd1;
         default: return $urandom & mask;
      endcase
   endfunction

   // ---------------- directed vectors for unit 0 ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs[NV];

   // ---------------- main sequence ----------------
   initial begin
      logic [33:0] res, expv;
      logic [33:0] prev;
      int lat, seen;

      vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[2]  = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
      vecs[3]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
      vecs[4]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
      vecs[5]  = '{32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 32'h0000_5555, 1'b0, 1'b0};
      vecs[6]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
      vecs[7]  = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
      vecs[8]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
      vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
      vecs[10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};

      for (int u = 0; u < NU; u++) begin
         d_valid[u]  = 1'b0;
         d_oready[u] = 1'b0;
         d_cin[u]    = 1'b0;
         d_sub[u]    = 1'b0;
         d_a[u]      = '0;
         d_b[u]      = '0;
      end

      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int u = 0; u < NU; u++) begin
         check($sformatf("u%0d_reset_in_ready", u), 64'(get_iready(u)), 64'd1);
         check($sformatf("u%0d_reset_out_valid", u), 64'(get_ovalid(u)), 64'd0);
         check($sformatf("u%0d_reset_result", u), 64'(get_res(u)), 64'd0);
      end

      // directed table on unit 0
      for (int i = 0; i < NV; i++) begin
         send(0, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
         recv(0, i % 3, 1'b0, res, lat);
         check($sformatf("vec%0d_result", i), 64'(res), 64'({vecs[i].ovf, vecs[i].cout, vecs[i].sum}));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd8);
      end

      // early out_ready: consumed on the first DONE cycle
      send(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      recv(0, 0, 1'b1, res, lat);
      check("early_ready_result", 64'(res), 64'({2'b00, 32'h0000_0100}));
      check("early_ready_latency", 64'(lat), 64'd8);

      // backpressure: 5 cycles of out_ready low with in_valid pulses that must be ignored
      expv = model(32, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      send(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0);
      wait_ovalid(0, lat);
      check("bp_latency", 64'(lat), 64'd8);
      for (int i = 0; i < 5; i++) begin
         d_valid[0] = (i % 2 == 0);
         d_a[0]     = 32'hDEAD_0000 + 32'(i);
         d_b[0]     = 32'h0000_BEEF;
         @(negedge clk);
         check($sformatf("bp%0d_out_valid", i), 64'(get_ovalid(0)), 64'd1);
         check($sformatf("bp%0d_in_ready", i), 64'(get_iready(0)), 64'd0);
         check($sformatf("bp%0d_result", i), 64'(get_res(0)), 64'(expv));
      end
      d_valid[0]  = 1'b0;
      d_oready[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      d_oready[0] = 1'b0;
      check("bp_in_ready_after_consume", 64'(get_iready(0)), 64'd1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (get_ovalid(0) || !get_iready(0)) seen++;
      end
      check("bp_no_ghost_op", 64'(seen), 64'd0);
      prev = expv;

      // reset while chunk 3 is being processed
      send(0, 32'hAAAA_5555, 32'h1111_1111, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("midrun_state_run", 64'(get_dbg(0)), 64'd1);
      check("midrun_result_held", 64'(get_res(0)), 64'(prev));
      rst_n = 1'b0;
      #1;
      check("midrun_reset_out_valid", 64'(get_ovalid(0)), 64'd0);
      check("midrun_reset_result", 64'(get_res(0)), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (get_ovalid(0)) seen++;
      end
      check("midrun_no_out_valid", 64'(seen), 64'd0);
      send(0, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0);
      recv(0, 1, 1'b0, res, lat);
      check("after_reset_result", 64'(res), 64'({2'b00, 32'h0000_5555}));

      // random traffic with stalls on units 1 and 2
      for (int u = 1; u < NU; u++) begin
         for (int i = 0; i < 1000; i++) begin
            logic [31:0] ra, rb;
            logic rc, rs, early;
            int stall;
            ra    = pick(w_of(u));
            rb    = pick(w_of(u));
            rc    = 1'($urandom_range(0, 1));
            rs    = 1'($urandom_range(0, 1));
            early = ($urandom_range(0, 3) == 0);
            stall = early ? 0 : $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            exp_q.push_back(model(w_of(u), ra, rb, rc, rs));
            send(u, ra, rb, rc, rs);
            recv(u, stall, early, res, lat);
            expv = exp_q.pop_front();
            check($sformatf("u%0d_rand%0d_result a=%0h b=%0h cin=%0b sub=%0b", u, i, ra, rb, rc, rs),
                  64'(res), 64'(expv));
            check($sformatf("u%0d_rand%0d_latency", u, i), 64'(lat), 64'(n_of(u)));
         end
      end

      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
